// File: rtl/phase_sequencer.sv
// Instruction phase generator for the VeriRisc core: free-run, single-step,
// halt/resume and memory wait-states with a bounded stall timeout.
module phase_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic             rd,
    input  logic             wr,
    input  logic             mem_ready,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             halted,
    output logic             stalled,
    output logic             timeout_err,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_WAIT,
        S_HALT
    } state_t;

    state_t           state_q;
    logic [2:0]       phase_q;
    logic [WCW-1:0]   wait_cnt_q;
    logic             to_q;
    logic             done_q;
    logic             stop_q;
    logic             run_q;
    logic             orig_step_q;
    logic [CNT_W-1:0] cnt_q;

    logic stall_req;
    logic run_rise;
    logic active;
    logic adv;
    logic wait_go;
    logic resume;
    logic inc;
    logic wrap;
    logic wait_to;
    logic run_mode;
    logic go_idle;

    always_comb begin
        stall_req = (rd | wr) & ~mem_ready;
        run_rise  = run & ~run_q;
        active    = (state_q == S_RUN) | (state_q == S_STEP);
        adv       = active & ~halt & ~stall_req;
        wait_go   = (state_q == S_WAIT) & mem_ready;
        resume    = (state_q == S_HALT) & ~to_q & (run_rise | step);
        inc       = adv | wait_go | resume;
        wrap      = inc & (phase_q == 3'd7);
        wait_to   = (state_q == S_WAIT) & ~mem_ready
                  & (wait_cnt_q >= WCW'(WAIT_MAX - 1));
        run_mode  = (state_q == S_RUN)
                  | ((state_q == S_WAIT) & ~orig_step_q);
        // stop only once run has been seen low before the boundary cycle
        go_idle   = stop_q & ~run;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            phase_q     <= 3'd0;
            wait_cnt_q  <= '0;
            to_q        <= 1'b0;
            done_q      <= 1'b0;
            stop_q      <= 1'b0;
            run_q       <= 1'b0;
            orig_step_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            run_q  <= run;
            done_q <= wrap;
            stop_q <= run_mode & ~run;
            if (wrap)
                cnt_q <= cnt_q + 1'b1;
            if (wait_to)
                to_q <= 1'b1;
            else if (err_clr)
                to_q <= 1'b0;
            if (inc)
                phase_q <= phase_q + 3'd1;

            unique case (state_q)
                S_IDLE: begin
                    phase_q    <= 3'd0;
                    wait_cnt_q <= '0;
                    if (run)
                        state_q <= S_RUN;
                    else if (step)
                        state_q <= S_STEP;
                end
                S_RUN, S_STEP: begin
                    if (halt) begin
                        state_q <= S_HALT;
                    end else if (stall_req) begin
                        state_q     <= S_WAIT;
                        wait_cnt_q  <= WCW'(1);
                        orig_step_q <= (state_q == S_STEP);
                    end else if (wrap && ((state_q == S_STEP) || go_idle)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        wait_cnt_q <= '0;
                        if (wrap && (orig_step_q || go_idle))
                            state_q <= S_IDLE;
                        else
                            state_q <= orig_step_q ? S_STEP : S_RUN;
                    end else if (wait_to) begin
                        wait_cnt_q <= '0;
                        state_q    <= S_HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_HALT: begin
                    if (!to_q) begin
                        if (run_rise)
                            state_q <= S_RUN;
                        else if (step)
                            state_q <= S_STEP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign phase       = phase_q;
    assign busy        = active | (state_q == S_WAIT);
    assign halted      = (state_q == S_HALT);
    assign stalled     = (state_q == S_WAIT);
    assign timeout_err = to_q;
    assign instr_done  = done_q;
    assign instr_count = cnt_q;

endmodule
